piso_tx: RTL and testbench

Parallel-in serial-out transmitter. It accepts an N-bit word over a valid/ready handshake and drives it onto a one-bit serial line, one bit per clock, with a valid qualifier and a last-bit marker. It is the sending end of the serial shift-register path and feeds a serial-in shift chain or deserializer downstream. Back-to-back words stream with no idle gap.

---
 rtl/piso_tx.sv | 111 +++++++++++
 tb/tb_piso_tx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
//------------------------------------------------------------------------------
// Module      : piso_tx
// Description : Parallel-in serial-out transmitter with a valid/ready load
//               port and a valid/last-qualified one-bit serial output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_tx #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    input  logic [N-1:0] data_in,
    output logic         load_ready,
    output logic         serial_out,
    output logic         serial_valid,
    output logic         serial_last
);

    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;

    localparam logic [0:0]       c_IDLE  = 1'b0;
    localparam logic [0:0]       c_SHIFT = 1'b1;
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    logic [0:0]       r_state;
    logic [N-1:0]     r_shift_reg;
    logic [CNT_W-1:0] r_bit_cnt;

    logic [0:0]       w_next_state;
    logic [N-1:0]     w_next_shift_reg;
    logic [CNT_W-1:0] w_next_bit_cnt;
    logic [N-1:0]     w_shifted;
    logic             w_head_bit;
    logic             w_in_shift;
    logic             w_at_last;
    logic             w_accept;

    // Bit order is fixed at elaboration: pick the outgoing bit and the
    // direction of the zero-filling shift.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head_bit = r_shift_reg[N-1];
            assign w_shifted  = {r_shift_reg[N-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head_bit = r_shift_reg[0];
            assign w_shifted  = {1'b0, r_shift_reg[N-1:1]};
        end
    endgenerate

    assign w_in_shift = (r_state == c_SHIFT);
    assign w_at_last  = (r_bit_cnt == c_LAST);

    // Ready on the last bit lets the next word follow with no idle gap.
    assign load_ready   = rst && (!w_in_shift || w_at_last);
    assign w_accept     = load_valid && load_ready;

    assign serial_valid = w_in_shift;
    assign serial_out   = w_in_shift && w_head_bit;
    assign serial_last  = w_in_shift && w_at_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_state     <= w_next_state;
            r_shift_reg <= w_next_shift_reg;
            r_bit_cnt   <= w_next_bit_cnt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_shift_reg = r_shift_reg;
        w_next_bit_cnt   = r_bit_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state     = c_SHIFT;
                    w_next_shift_reg = data_in;
                    w_next_bit_cnt   = '0;
                end
            end
            c_SHIFT: begin
                if (w_accept) begin
                    w_next_shift_reg = data_in;
                    w_next_bit_cnt   = '0;
                end else if (w_at_last) begin
                    w_next_state     = c_IDLE;
                    w_next_shift_reg = w_shifted;
                    w_next_bit_cnt   = '0;
                end else begin
                    w_next_shift_reg = w_shifted;
                    w_next_bit_cnt   = r_bit_cnt + c_ONE;
                end
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_piso_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx (N=4 MSB-first, N=8 LSB-first).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // N=4, MSB first
    logic       rst_a = 1'b0;
    logic       lv_a  = 1'b0;
    logic [3:0] din_a = 4'h0;
    logic       rdy_a, out_a, val_a, last_a;

    // N=8, LSB first
    logic       rst_b = 1'b0;
    logic       lv_b  = 1'b0;
    logic [7:0] din_b = 8'h00;
    logic       rdy_b, out_b, val_b, last_b;

    piso_tx #(.N(4), .MSB_FIRST(1'b1)) u_dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .load_valid   (lv_a),
        .data_in      (din_a),
        .load_ready   (rdy_a),
        .serial_out   (out_a),
        .serial_valid (val_a),
        .serial_last  (last_a)
    );

    piso_tx #(.N(8), .MSB_FIRST(1'b0)) u_dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .load_valid   (lv_b),
        .data_in      (din_b),
        .load_ready   (rdy_b),
        .serial_out   (out_b),
        .serial_valid (val_b),
        .serial_last  (last_b)
    );

    typedef struct {
        bit       rst;
        bit       lv;
        bit [3:0] din;
        bit       ev;
        bit       eo;
        bit       el;
        bit       er;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input bit r, input bit lv, input bit [3:0] d,
                       input bit ev, input bit eo, input bit el, input bit er);
        vec_t v;
        v.rst = r; v.lv = lv; v.din = d;
        v.ev = ev; v.eo = eo; v.el = el; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic act, input bit exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%b expected=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        bit [7:0] word_b;

        // Inputs in each row are applied just after an edge; expected values
        // describe the outputs in that same cycle, before the next edge.
        // reset held with load_valid=1
        add(0,1,4'hF, 0,0,0,0);
        add(0,1,4'hF, 0,0,0,0);
        // 1011 MSB first, data_in changes after accept
        add(1,1,4'hB, 0,0,0,1);
        add(1,0,4'h4, 1,1,0,0);
        add(1,0,4'h4, 1,0,0,0);
        add(1,0,4'h4, 1,1,0,0);
        add(1,0,4'h4, 1,1,1,1);
        // back-to-back 1011 then 0110
        add(1,1,4'hB, 0,0,0,1);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,0,0,0);
        add(1,0,4'h0, 1,1,0,0);
        add(1,1,4'h6, 1,1,1,1);
        add(1,0,4'h0, 1,0,0,0);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,0,1,1);
        // 1000 with 1111 offered mid-word (ignored), then sent from IDLE
        add(1,1,4'h8, 0,0,0,1);
        add(1,0,4'h0, 1,1,0,0);
        add(1,1,4'hF, 1,0,0,0);
        add(1,0,4'h0, 1,0,0,0);
        add(1,0,4'h0, 1,0,1,1);
        add(1,1,4'hF, 0,0,0,1);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,1,1,1);
        // reset during 2nd bit of 1011, then 0101
        add(1,1,4'hB, 0,0,0,1);
        add(1,0,4'h0, 1,1,0,0);
        add(0,0,4'h0, 1,0,0,0);
        add(1,1,4'h5, 0,0,0,1);
        add(1,0,4'h0, 1,0,0,0);
        add(1,0,4'h0, 1,1,0,0);
        add(1,0,4'h0, 1,0,0,0);
        add(1,0,4'h0, 1,1,1,1);
        add(1,0,4'h0, 0,0,0,1);

        // one reset edge so all registers are defined before checking
        rst_a = 1'b0; lv_a = 1'b1; din_a = 4'hF;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst;
            lv_a  = vecs[i].lv;
            din_a = vecs[i].din;
            #3;
            check("a_valid", i, val_a,  vecs[i].ev);
            check("a_out",   i, out_a,  vecs[i].eo);
            check("a_last",  i, last_a, vecs[i].el);
            check("a_ready", i, rdy_a,  vecs[i].er);
            @(posedge clk); #1;
        end
        lv_a = 1'b0;

        // N=8 LSB first: 8'hA5 -> 1,0,1,0,0,1,0,1
        rst_b = 1'b0; lv_b = 1'b0;
        @(posedge clk); #1;
        #3;
        check("b_rst_valid", 0, val_b, 1'b0);
        check("b_rst_ready", 0, rdy_b, 1'b0);
        rst_b = 1'b1; lv_b = 1'b1; din_b = 8'hA5;
        #1;
        check("b_idle_ready", 0, rdy_b, 1'b1);
        @(posedge clk); #1;
        lv_b = 1'b0; din_b = 8'hFF;
        word_b = 8'b1010_0101;
        for (int k = 0; k < 8; k++) begin
            #3;
            check("b_valid", k, val_b,  1'b1);
            check("b_out",   k, out_b,  word_b[k]);
            check("b_last",  k, last_b, (k == 7));
            @(posedge clk); #1;
        end
        #3;
        check("b_end_valid", 8, val_b, 1'b0);
        check("b_end_out",   8, out_b, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
